cpu_control_unit: RTL and testbench

Hardwired sequencer for the 16-bit CPU execution unit. It replaces the manual switch inputs (pc_ld, pc_inc, ir_ld, adr_sel, s_sel, reg_w_en, mem_w_en) with a fetch/decode/execute state machine. It decodes the instruction register and status flags from the execution unit and supports continuous run or single-instruction step. It sits between the execution unit, the main memory write-enable and the board-level run/step controls in the top level.

---
 rtl/cpu_control_unit.sv | 178 +++++++++++++++++
 tb/tb_cpu_control_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: hardwired fetch/decode/execute sequencer for the 16-bit CPU.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   run, step         free-run level / single-step pulse from board controls
//   ir, C, N, Z       instruction register and status flags from the execution unit
//   pc_ld, pc_inc, ir_ld, adr_sel, s_sel, reg_w_en, mem_w_en, alu_op
//                     datapath controls, registered
//   halted, illegal   stop indicators; state is the current state encoding
module cpu_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic [15:0] ir,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        ir_ld,
  output logic        adr_sel,
  output logic        s_sel,
  output logic        reg_w_en,
  output logic        mem_w_en,
  output logic [3:0]  alu_op,
  output logic        halted,
  output logic        illegal,
  output logic [3:0]  state
);

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_ALU = 4'h1;
  localparam logic [OP_W-1:0] OP_LD  = 4'h2;
  localparam logic [OP_W-1:0] OP_ST  = 4'h3;
  localparam logic [OP_W-1:0] OP_JMP = 4'h4;
  localparam logic [OP_W-1:0] OP_BR  = 4'h5;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE     = 4'h0,
    S_FETCH    = 4'h1,
    S_FETCH_WB = 4'h2,
    S_DECODE   = 4'h3,
    S_EX_ALU   = 4'h4,
    S_LD_ADR   = 4'h5,
    S_LD_WB    = 4'h6,
    S_ST_WR    = 4'h7,
    S_EX_JMP   = 4'h8,
    S_EX_BR    = 4'h9,
    S_HALT     = 4'hA,
    S_ILLEGAL  = 4'hB
  } state_t;

  state_t          state_q, state_nxt, end_state;
  logic [OP_W-1:0] opcode;
  logic            br_take;
  logic            pc_ld_nxt, pc_inc_nxt, ir_ld_nxt, adr_sel_nxt, s_sel_nxt;
  logic            reg_w_en_nxt, mem_w_en_nxt, halted_nxt, illegal_nxt;
  logic [3:0]      alu_op_nxt;

  // Immediate/operand field is consumed by the datapath, not the sequencer.
  logic unused_ir_low;
  assign unused_ir_low = ^ir[7:0];

  assign opcode = ir[15:12];
  assign state  = state_q;

  // Branch condition; ir and flags are stable from DECODE into EX_BR.
  always_comb begin
    br_take = 1'b0;
    case (ir[11:10])
      2'b00:   br_take = Z;
      2'b01:   br_take = N;
      2'b10:   br_take = C;
      default: br_take = 1'b1;
    endcase
  end

  // Next state, then outputs decoded from the next state so they register in step with it.
  always_comb begin
    state_nxt    = state_q;
    end_state    = run ? S_FETCH : S_IDLE;
    pc_ld_nxt    = 1'b0;
    pc_inc_nxt   = 1'b0;
    ir_ld_nxt    = 1'b0;
    adr_sel_nxt  = 1'b0;
    s_sel_nxt    = 1'b0;
    reg_w_en_nxt = 1'b0;
    mem_w_en_nxt = 1'b0;
    alu_op_nxt   = 4'h0;
    halted_nxt   = 1'b0;
    illegal_nxt  = 1'b0;

    case (state_q)
      S_IDLE:     if (run || step) state_nxt = S_FETCH;
      S_FETCH:    state_nxt = S_FETCH_WB;
      S_FETCH_WB: state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOP:  state_nxt = end_state;
          OP_ALU:  state_nxt = S_EX_ALU;
          OP_LD:   state_nxt = S_LD_ADR;
          OP_ST:   state_nxt = S_ST_WR;
          OP_JMP:  state_nxt = S_EX_JMP;
          OP_BR:   state_nxt = S_EX_BR;
          OP_HLT:  state_nxt = S_HALT;
          default: state_nxt = S_ILLEGAL;
        endcase
      end
      S_LD_ADR:   state_nxt = S_LD_WB;
      S_EX_ALU, S_LD_WB, S_ST_WR, S_EX_JMP, S_EX_BR: state_nxt = end_state;
      S_HALT:     state_nxt = S_HALT;
      S_ILLEGAL:  state_nxt = S_ILLEGAL;
      default:    state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_FETCH_WB: begin
        ir_ld_nxt  = 1'b1;
        pc_inc_nxt = 1'b1;
      end
      S_EX_ALU: begin
        reg_w_en_nxt = 1'b1;
        alu_op_nxt   = ir[11:8];
      end
      S_LD_ADR: adr_sel_nxt = 1'b1;
      S_LD_WB: begin
        adr_sel_nxt  = 1'b1;
        s_sel_nxt    = 1'b1;
        reg_w_en_nxt = 1'b1;
      end
      S_ST_WR: begin
        adr_sel_nxt  = 1'b1;
        mem_w_en_nxt = 1'b1;
      end
      S_EX_JMP:  pc_ld_nxt = 1'b1;
      S_EX_BR:   pc_ld_nxt = br_take;
      S_HALT:    halted_nxt = 1'b1;
      S_ILLEGAL: begin
        halted_nxt  = 1'b1;
        illegal_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers; reset clears every strobe on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_ld    <= 1'b0;
      pc_inc   <= 1'b0;
      ir_ld    <= 1'b0;
      adr_sel  <= 1'b0;
      s_sel    <= 1'b0;
      reg_w_en <= 1'b0;
      mem_w_en <= 1'b0;
      alu_op   <= 4'h0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      pc_ld    <= pc_ld_nxt;
      pc_inc   <= pc_inc_nxt;
      ir_ld    <= ir_ld_nxt;
      adr_sel  <= adr_sel_nxt;
      s_sel    <= s_sel_nxt;
      reg_w_en <= reg_w_en_nxt;
      mem_w_en <= mem_w_en_nxt;
      alu_op   <= alu_op_nxt;
      halted   <= halted_nxt;
      illegal  <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with a minimal IR/PC model of the execution unit.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        reset, run, step, C, N, Z;
  logic [15:0] ir;
  logic        pc_ld, pc_inc, ir_ld, adr_sel, s_sel, reg_w_en, mem_w_en;
  logic [3:0]  alu_op, state;
  logic        halted, illegal;

  logic [15:0] prog [0:15];
  int unsigned pc;
  int          vectors = 0;
  int          miscompares = 0;

  cpu_control_unit dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .ir(ir),
    .C(C), .N(N), .Z(Z),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .ir_ld(ir_ld), .adr_sel(adr_sel),
    .s_sel(s_sel), .reg_w_en(reg_w_en), .mem_w_en(mem_w_en),
    .alu_op(alu_op), .halted(halted), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Strobe bundle: {pc_ld, pc_inc, ir_ld, adr_sel, s_sel, reg_w_en, mem_w_en}
  function automatic logic [6:0] strobes();
    return {pc_ld, pc_inc, ir_ld, adr_sel, s_sel, reg_w_en, mem_w_en};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; the EU model latches IR and bumps PC on the edge ending a strobed cycle.
  task automatic tick();
    logic ld, inc;
    ld  = ir_ld;
    inc = pc_inc;
    @(posedge clk);
    #1;
    if (ld === 1'b1) ir = prog[pc];
    if (inc === 1'b1) pc = pc + 1;
  endtask

  task automatic cyc(input string tag, input logic [3:0] st, input logic [6:0] sb);
    tick();
    chk({tag, ".state"}, 16'(state), 16'(st));
    chk({tag, ".strobes"}, 16'(strobes()), 16'(sb));
  endtask

  task automatic step_pulse();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  localparam logic [6:0] SB_NONE  = 7'b0000000;
  localparam logic [6:0] SB_FWB   = 7'b0110000;
  localparam logic [6:0] SB_ALU   = 7'b0000010;
  localparam logic [6:0] SB_LDADR = 7'b0001000;
  localparam logic [6:0] SB_LDWB  = 7'b0001110;
  localparam logic [6:0] SB_ST    = 7'b0001001;
  localparam logic [6:0] SB_PCLD  = 7'b1000000;

  // Expected run-mode trace for NOP, LD, ST, HLT starting at FETCH.
  logic [3:0] run_st [0:15] = '{4'h1, 4'h2, 4'h3, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6,
                                4'h1, 4'h2, 4'h3, 4'h7, 4'h1, 4'h2, 4'h3, 4'hA};
  logic [6:0] run_sb [0:15] = '{SB_NONE, SB_FWB, SB_NONE, SB_NONE, SB_FWB, SB_NONE,
                                SB_LDADR, SB_LDWB, SB_NONE, SB_FWB, SB_NONE, SB_ST,
                                SB_NONE, SB_FWB, SB_NONE, SB_NONE};

  initial begin
    int mem_w_cycles;
    for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
    prog[0]  = 16'h1305;  // ALU op 3
    prog[1]  = 16'h0000;  // NOP
    prog[2]  = 16'h2100;  // LD
    prog[3]  = 16'h3200;  // ST
    prog[4]  = 16'hF000;  // HLT
    prog[5]  = 16'h5000;  // BR on Z, Z=1
    prog[6]  = 16'h5000;  // BR on Z, Z=0
    prog[7]  = 16'h5C00;  // BR always
    prog[8]  = 16'h5400;  // BR on N
    prog[9]  = 16'h4000;  // JMP
    prog[10] = 16'h7000;  // illegal
    prog[11] = 16'h3000;  // ST, reset lands mid-instruction
    prog[12] = 16'h2000;  // LD, reset lands mid-instruction
    pc = 0; ir = 16'h0000;
    reset = 1'b1; run = 1'b0; step = 1'b0; C = 1'b0; N = 1'b0; Z = 1'b0;

    tick(); tick();
    chk("reset.state", 16'(state), 16'h0);
    chk("reset.strobes", 16'(strobes()), 16'(SB_NONE));
    chk("reset.alu_op", 16'(alu_op), 16'h0);
    chk("reset.halted", 16'({halted, illegal}), 16'h0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) cyc("idle", 4'h0, SB_NONE);

    // Single step of ALU op 3, with stray step pulses in FETCH_WB and EX_ALU.
    step_pulse();
    chk("alu.fetch", 16'(state), 16'h1);
    chk("alu.fetch.strobes", 16'(strobes()), 16'(SB_NONE));
    cyc("alu.fwb", 4'h2, SB_FWB);
    step = 1'b1;
    cyc("alu.dec", 4'h3, SB_NONE);
    step = 1'b0;
    cyc("alu.ex", 4'h4, SB_ALU);
    chk("alu.op", 16'(alu_op), 16'h3);
    step = 1'b1;
    cyc("alu.end", 4'h0, SB_NONE);
    step = 1'b0;
    chk("alu.op_clr", 16'(alu_op), 16'h0);
    cyc("alu.no_queue", 4'h0, SB_NONE);
    chk("alu.pc", 16'(pc), 16'h1);

    // Free run with run and step both high at the start.
    run = 1'b1; step = 1'b1;
    mem_w_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      step = 1'b0;
      if (mem_w_en === 1'b1) mem_w_cycles++;
      chk($sformatf("run%0d.state", i), 16'(state), 16'(run_st[i]));
      chk($sformatf("run%0d.strobes", i), 16'(strobes()), 16'(run_sb[i]));
    end
    chk("run.halted", 16'({halted, illegal}), 16'h2);
    chk("run.mem_w_cycles", 16'(mem_w_cycles), 16'h1);
    run = 1'b0; step = 1'b1;
    cyc("halt.hold1", 4'hA, SB_NONE);
    step = 1'b0; run = 1'b1;
    cyc("halt.hold2", 4'hA, SB_NONE);
    run = 1'b0; reset = 1'b1;
    cyc("halt.reset", 4'h0, SB_NONE);
    reset = 1'b0;
    chk("halt.cleared", 16'(halted), 16'h0);

    // Branches and jump in step mode.
    Z = 1'b1;
    step_pulse(); cyc("brz1.fwb", 4'h2, SB_FWB); cyc("brz1.dec", 4'h3, SB_NONE);
    cyc("brz1.ex", 4'h9, SB_PCLD); cyc("brz1.end", 4'h0, SB_NONE);
    Z = 1'b0;
    step_pulse(); cyc("brz0.fwb", 4'h2, SB_FWB); cyc("brz0.dec", 4'h3, SB_NONE);
    cyc("brz0.ex", 4'h9, SB_NONE); cyc("brz0.end", 4'h0, SB_NONE);
    step_pulse(); cyc("bral.fwb", 4'h2, SB_FWB); cyc("bral.dec", 4'h3, SB_NONE);
    cyc("bral.ex", 4'h9, SB_PCLD); cyc("bral.end", 4'h0, SB_NONE);
    N = 1'b1;
    step_pulse(); cyc("brn.fwb", 4'h2, SB_FWB); cyc("brn.dec", 4'h3, SB_NONE);
    cyc("brn.ex", 4'h9, SB_PCLD); cyc("brn.end", 4'h0, SB_NONE);
    N = 1'b0;
    step_pulse(); cyc("jmp.fwb", 4'h2, SB_FWB); cyc("jmp.dec", 4'h3, SB_NONE);
    cyc("jmp.ex", 4'h8, SB_PCLD); cyc("jmp.end", 4'h0, SB_NONE);

    // Illegal opcode traps until reset.
    step_pulse(); cyc("ill.fwb", 4'h2, SB_FWB); cyc("ill.dec", 4'h3, SB_NONE);
    cyc("ill.trap", 4'hB, SB_NONE);
    chk("ill.flags", 16'({halted, illegal}), 16'h3);
    run = 1'b1; step = 1'b1;
    cyc("ill.hold1", 4'hB, SB_NONE);
    run = 1'b0;
    cyc("ill.hold2", 4'hB, SB_NONE);
    step = 1'b0;
    reset = 1'b1;
    cyc("ill.reset", 4'h0, SB_NONE);
    reset = 1'b0;
    chk("ill.cleared", 16'({halted, illegal}), 16'h0);

    // Reset during ST_WR and LD_ADR.
    step_pulse(); cyc("rst_st.fwb", 4'h2, SB_FWB); cyc("rst_st.dec", 4'h3, SB_NONE);
    cyc("rst_st.wr", 4'h7, SB_ST);
    reset = 1'b1;
    cyc("rst_st.after", 4'h0, SB_NONE);
    reset = 1'b0;
    step_pulse(); cyc("rst_ld.fwb", 4'h2, SB_FWB); cyc("rst_ld.dec", 4'h3, SB_NONE);
    cyc("rst_ld.adr", 4'h5, SB_LDADR);
    reset = 1'b1;
    cyc("rst_ld.after", 4'h0, SB_NONE);
    reset = 1'b0;
    cyc("rst_ld.idle", 4'h0, SB_NONE);
    chk("final.pc", 16'(pc), 16'hD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
